// File: rtl/sha1_padder.sv
// sha1_padder
// Message-side producer for the SHA-1 core. It takes a byte-granular message
// as 32-bit big-endian words and appends the 0x80 marker, zero fill and the
// 64-bit big-endian bit length. Finished 512-bit blocks go out over a
// valid/ready handshake, and block_last_o marks the final block of each
// message.
//
// Ports
//   clk_i, rst_i      clock (rising edge), async active-high reset
//   clear_i           synchronous abort of the current message
//   msg_word_i        message word, first byte in [31:24]
//   msg_valid_i       msg_word_i valid
//   msg_ready_o       padder accepts a word this cycle
//   msg_last_i        word is the last word of the message
//   msg_bytes_i       valid bytes in the last word (0 means 4)
//   block_o           padded block, word 0 in [511:480]
//   block_valid_o     block_o valid
//   block_ready_i     consumer accepts block_o
//   block_last_o      block_o is the final block of the message
//   busy_o            a message is in progress or a block is pending
//
// state | meaning
// FILL  | accepting message words into the block buffer
// PAD   | writing marker/zero/length words, one per cycle
// EMIT  | holding a full block until the consumer takes it
module sha1_padder #(
    parameter int BlockWidth = 512,
    parameter int WordSize   = 32,
    parameter int LenWidth   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [WordSize-1:0]   msg_word_i,
    input  logic                  msg_valid_i,
    output logic                  msg_ready_o,
    input  logic                  msg_last_i,
    input  logic [1:0]            msg_bytes_i,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic                  block_last_o,
    output logic                  busy_o
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] PAD  = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0]          state_q;
    logic [1:0]          resume_q;
    logic                final_q;
    logic                mark_q;
    logic [3:0]          cntr_q;
    logic [LenWidth-1:0] len_q;
    // Index 0 is the most significant word, so the buffer maps straight onto block_o.
    logic [0:15][31:0]   buf_q;

    logic [31:0]         last_word;
    logic [LenWidth-1:0] len_add;

    // Keep the top n bytes of a partial last word, then place the marker right after them.
    always_comb begin
        last_word = msg_word_i;
        case (msg_bytes_i)
            2'd1:    last_word = {msg_word_i[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {msg_word_i[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {msg_word_i[31:8], 8'h80};
            default: last_word = msg_word_i;
        endcase
    end

    always_comb begin
        len_add = LenWidth'(32);
        if (msg_last_i && (msg_bytes_i != 2'd0))
            len_add = LenWidth'({msg_bytes_i, 3'b000});
    end

    assign msg_ready_o   = (state_q == FILL) & ~clear_i;
    assign block_valid_o = (state_q == EMIT);
    assign block_last_o  = (state_q == EMIT) & final_q;
    assign block_o       = buf_q;
    assign busy_o        = (state_q != FILL) | (cntr_q != 4'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= FILL;
            resume_q <= FILL;
            final_q  <= 1'b0;
            mark_q   <= 1'b0;
            cntr_q   <= 4'd0;
            len_q    <= '0;
            buf_q    <= '0;
        end else if (clear_i) begin
            state_q  <= FILL;
            resume_q <= FILL;
            final_q  <= 1'b0;
            mark_q   <= 1'b0;
            cntr_q   <= 4'd0;
            len_q    <= '0;
            buf_q    <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (msg_valid_i) begin
                        buf_q[cntr_q] <= msg_last_i ? last_word : msg_word_i;
                        cntr_q        <= cntr_q + 4'd1;
                        len_q         <= len_q + len_add;
                        if (msg_last_i) begin
                            // A full last word leaves the marker for the padding phase.
                            if (msg_bytes_i == 2'd0)
                                mark_q <= 1'b1;
                            if (cntr_q == 4'd15) begin
                                state_q  <= EMIT;
                                final_q  <= 1'b0;
                                resume_q <= PAD;
                            end else begin
                                state_q <= PAD;
                            end
                        end else if (cntr_q == 4'd15) begin
                            state_q  <= EMIT;
                            final_q  <= 1'b0;
                            resume_q <= FILL;
                        end
                    end
                end
                PAD: begin
                    if ((cntr_q == 4'd14) && !mark_q) begin
                        buf_q[14] <= len_q[63:32];
                        buf_q[15] <= len_q[31:0];
                        state_q   <= EMIT;
                        final_q   <= 1'b1;
                    end else begin
                        buf_q[cntr_q] <= mark_q ? 32'h8000_0000 : 32'h0000_0000;
                        mark_q        <= 1'b0;
                        cntr_q        <= cntr_q + 4'd1;
                        // No room left for the length in this block; spill into another one.
                        if (cntr_q == 4'd15) begin
                            state_q  <= EMIT;
                            final_q  <= 1'b0;
                            resume_q <= PAD;
                        end
                    end
                end
                EMIT: begin
                    if (block_ready_i) begin
                        buf_q  <= '0;
                        cntr_q <= 4'd0;
                        if (final_q) begin
                            len_q   <= '0;
                            state_q <= FILL;
                        end else begin
                            state_q <= resume_q;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: doc/sha1_padder.md
Name: sha1_padder

Overview:
Message-side producer for the SHA-1 engine. It accepts a byte-granular message as a stream of 32-bit big-endian words. It appends the FIPS 180-4 padding: a 0x80 marker, zero fill, and the 64-bit big-endian bit length. It emits complete 512-bit blocks over a valid/ready handshake, flagging the final block of each message. It sits between the bus/FIFO front end and the hash core's block input.

Parameters:
BlockWidth, 512, block size in bits; must be 512.
WordSize, 32, message word width in bits.
LenWidth, 64, message bit-length counter width; wraps modulo 2^LenWidth.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
clear_i  in  1  synchronous abort of the current message.
msg_word_i  in  32  message word; first byte in bits [31:24].
msg_valid_i  in  1  msg_word_i valid.
msg_ready_o  out  1  padder accepts a word this cycle.
msg_last_i  in  1  word is the last word of the message.
msg_bytes_i  in  2  valid bytes in the last word (1..3; 0 means 4); ignored unless msg_last_i.
block_o  out  512  padded block; word 0 in bits [511:480].
block_valid_o  out  1  block_o valid.
block_ready_i  in  1  consumer accepts block_o.
block_last_o  out  1  block_o is the final block of the message; qualified by block_valid_o.
busy_o  out  1  state is not FILL, or the word counter is nonzero.

Behaviour:
- Reset values:
  - State FILL; word counter 0; bit length 0; block buffer 0; marker-pending 0.
  - block_valid_o=0, block_last_o=0, block_o=0, busy_o=0, msg_ready_o=1.
- State FILL:
  - msg_ready_o = ~clear_i.
  - Accept occurs when msg_valid_i & msg_ready_o. The word is written at index cntr, cntr increments, and length increments by 32.
  - Not last, cntr was 15: go to EMIT with the final flag clear, then return to FILL.
  - Last, n = msg_bytes_i in 1..3:
    - Keep the top n bytes.
    - Byte n becomes 0x80; the remaining bytes become zero.
    - Length increments by 8n.
    - Go to PAD.
  - Last, n = 4: set marker-pending, add 32 to length, go to PAD. If cntr was 15, go to EMIT non-final first, then PAD.
- State PAD: one word per cycle; msg_ready_o=0.
  - When cntr==14 and marker-pending=0: write length[63:32] into word 14 and length[31:0] into word 15 in the same cycle, then go to EMIT final.
  - Otherwise write 0x80000000 if marker-pending (then clear it), else 0x00000000, and increment cntr.
  - If that write lands at index 15, go to EMIT non-final, then resume PAD at cntr 0.
- State EMIT:
  - block_valid_o=1; block_o and block_last_o are held stable until block_ready_i.
  - msg_ready_o=0: single buffer, no overlap.
  - On handshake: buffer zeroed, cntr=0.
  - Final block: length cleared, go to FILL.
  - Non-final block: return to FILL or PAD according to the phase.
- Latency: a single-word message with n ≤ 3, accepted in FILL, has block_valid_o rise after 14 further rising edges, with no backpressure.
- clear_i:
  - Highest priority below rst_i, in any state.
  - Next cycle: FILL, cntr 0, length 0, buffer 0, marker-pending 0, block_valid_o 0. A pending block is dropped.
- Boundary conditions:
  - Empty messages are unsupported.
  - msg_bytes_i is ignored unless msg_last_i.
  - Length wraps silently.
  - Block ready may be held low indefinitely.

Test Plan:
1. "abc": one word 0x61626300, last, bytes=3 -> one final block: word0 0x61626380, words1-14 0, word15 0x00000018; valid 14 cycles after accept.
2. 55 bytes (13 full words + last bytes=3) -> one final block: word13 low byte 0x80, word14 0, word15 0x000001B8.
3. 56 bytes (14 full words, last bytes=0) -> two blocks:
   - Block 1 non-final: word14 0x80000000, word15 0.
   - Block 2 final: words0-14 0, word15 0x000001C0.
4. 64 bytes (16 full words) -> block 1 non-final (pure data); block 2 final: word0 0x80000000, word15 0x00000200.
5. Backpressure: block_ready_i low 10 cycles in EMIT -> block_o/block_last_o stable, block_valid_o high, msg_ready_o low throughout; handshake on cycle 11.
6. Abort: clear_i mid-PAD after a partial "abc", then a fresh "abc" -> only the test 1 block appears, length 0x18 (not 0x30).
